dnn_result_reader: RTL and testbench

Parametrised readout stage for the inference engine's output layer. When the engine signals completion, the block captures all class scores into a register bank and runs a sequential argmax scan to produce the predicted digit. It then streams every score out over a valid/ready interface. It also offers a registered random-access read port, and flags any read index that is out of range.

---
 rtl/dnn_readout_pkg.sv | 15 +
 rtl/dnn_argmax_step.sv | 26 ++
 rtl/dnn_result_reader.sv | 165 ++++++++++++++++
 tb/tb_dnn_result_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_readout_pkg.sv
// Shared types and defaults for the DNN output-layer readout stage.
package dnn_readout_pkg;

    localparam int unsigned DEFAULT_NUM_CLASSES = 10;
    localparam int unsigned DEFAULT_DATA_WIDTH  = 16;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] score_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STREAM
    } state_t;

endpackage

// File: rtl/dnn_argmax_step.sv
// One argmax step: signed compare of a candidate score against the running best.
module dnn_argmax_step
    import dnn_readout_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic        [IDX_WIDTH-1:0]  best_idx,
    input  logic signed [DATA_WIDTH-1:0] best_score,
    input  logic        [IDX_WIDTH-1:0]  cand_idx,
    input  logic signed [DATA_WIDTH-1:0] cand_score,
    output logic        [IDX_WIDTH-1:0]  sel_idx,
    output logic signed [DATA_WIDTH-1:0] sel_score
);

    logic take;

    // Equal scores resolve to the lower class index regardless of scan order.
    always_comb begin
        take = (cand_score > best_score) ||
               ((cand_score == best_score) && (cand_idx < best_idx));
        sel_idx   = take ? cand_idx   : best_idx;
        sel_score = take ? cand_score : best_score;
    end

endmodule

// File: rtl/dnn_result_reader.sv
// Output-layer readout: snapshot class scores, sequential argmax scan, then stream
// every score over valid/ready. Independent registered random-access read port.
module dnn_result_reader
    import dnn_readout_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    capture,
    input  logic [NUM_CLASSES-1:0][DATA_WIDTH-1:0]  scores,
    output logic                                    busy,
    output logic                                    pred_valid,
    output logic        [IDX_WIDTH-1:0]             pred_idx,
    output logic signed [DATA_WIDTH-1:0]            pred_score,
    output logic                                    m_valid,
    input  logic                                    m_ready,
    output logic signed [DATA_WIDTH-1:0]            m_data,
    output logic        [IDX_WIDTH-1:0]             m_idx,
    output logic                                    m_last,
    input  logic        [IDX_WIDTH-1:0]             rd_idx,
    output logic signed [DATA_WIDTH-1:0]            rd_data,
    output logic                                    rd_err
);

    typedef logic signed [DATA_WIDTH-1:0] word_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH:0]   NUM_CLS_EXT = (IDX_WIDTH + 1)'(NUM_CLASSES);

    state_t               state_q, state_d;
    word_t                snapshot_q [NUM_CLASSES];
    logic                 load;
    logic [IDX_WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic [IDX_WIDTH-1:0] best_idx_q, best_idx_d;
    word_t                best_score_q, best_score_d;
    logic                 pred_valid_q, pred_valid_d;
    logic [IDX_WIDTH-1:0] pred_idx_q, pred_idx_d;
    word_t                pred_score_q, pred_score_d;
    logic [IDX_WIDTH-1:0] m_idx_q, m_idx_d;
    logic [IDX_WIDTH-1:0] step_idx;
    word_t                step_score;
    word_t                rd_data_q;
    logic                 rd_err_q;
    logic                 rd_in_range;

    dnn_argmax_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_argmax_step (
        .best_idx   (best_idx_q),
        .best_score (best_score_q),
        .cand_idx   (scan_idx_q),
        .cand_score (snapshot_q[scan_idx_q]),
        .sel_idx    (step_idx),
        .sel_score  (step_score)
    );

    assign rd_in_range = {1'b0, rd_idx} < NUM_CLS_EXT;

    // Flop array rather than RAM: capture loads every entry in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snapshot_q[i] <= '0;
            end
            rd_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (load) begin
                for (int i = 0; i < NUM_CLASSES; i++) begin
                    snapshot_q[i] <= scores[i];
                end
            end
            rd_data_q <= rd_in_range ? snapshot_q[rd_idx] : '0;
            rd_err_q  <= ~rd_in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            scan_idx_q   <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            pred_valid_q <= 1'b0;
            pred_idx_q   <= '0;
            pred_score_q <= '0;
            m_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            scan_idx_q   <= scan_idx_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            pred_valid_q <= pred_valid_d;
            pred_idx_q   <= pred_idx_d;
            pred_score_q <= pred_score_d;
            m_idx_q      <= m_idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        scan_idx_d   = scan_idx_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        pred_valid_d = pred_valid_q;
        pred_idx_d   = pred_idx_q;
        pred_score_d = pred_score_q;
        m_idx_d      = m_idx_q;

        // Capture wins in every state, so a run in progress is simply restarted.
        if (capture) begin
            load         = 1'b1;
            state_d      = SCAN;
            best_idx_d   = '0;
            best_score_d = scores[0];
            scan_idx_d   = IDX_WIDTH'(1);
            pred_valid_d = 1'b0;
            m_idx_d      = '0;
        end else begin
            case (state_q)
                SCAN: begin
                    best_idx_d   = step_idx;
                    best_score_d = step_score;
                    if (scan_idx_q == LAST_IDX) begin
                        state_d      = STREAM;
                        pred_valid_d = 1'b1;
                        pred_idx_d   = step_idx;
                        pred_score_d = step_score;
                        m_idx_d      = '0;
                    end else begin
                        scan_idx_d = scan_idx_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (m_ready) begin
                        if (m_idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            m_idx_d = '0;
                        end else begin
                            m_idx_d = m_idx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign pred_valid = pred_valid_q;
    assign pred_idx   = pred_idx_q;
    assign pred_score = pred_score_q;
    assign m_valid    = (state_q == STREAM);
    assign m_idx      = m_idx_q;
    assign m_last     = m_valid && (m_idx_q == LAST_IDX);
    assign m_data     = m_valid ? snapshot_q[m_idx_q] : '0;
    assign rd_data    = rd_data_q;
    assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_dnn_result_reader.sv
// Directed self-checking bench for dnn_result_reader at default parameters.
module tb_dnn_result_reader;
    import dnn_readout_pkg::*;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  capture;
    logic [N-1:0][DW-1:0]  scores;
    logic                  busy;
    logic                  pred_valid;
    logic [IW-1:0]         pred_idx;
    logic signed [DW-1:0]  pred_score;
    logic                  m_valid;
    logic                  m_ready;
    logic signed [DW-1:0]  m_data;
    logic [IW-1:0]         m_idx;
    logic                  m_last;
    logic [IW-1:0]         rd_idx;
    logic signed [DW-1:0]  rd_data;
    logic                  rd_err;

    int     checks   = 0;
    int     failures = 0;
    score_t vec [N];
    int     beats;

    dnn_result_reader #(
        .NUM_CLASSES (N),
        .DATA_WIDTH  (DW),
        .IDX_WIDTH   (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .scores     (scores),
        .busy       (busy),
        .pred_valid (pred_valid),
        .pred_idx   (pred_idx),
        .pred_score (pred_score),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive vec onto scores and pulse capture across one rising edge.
    task automatic apply_capture();
        for (int i = 0; i < N; i++) scores[i] = vec[i];
        capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) step();
        chk("idle_reached", busy, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_pred_valid"}, pred_valid, 0);
        chk({tag, "_pred_idx"},   pred_idx,   0);
        chk({tag, "_pred_score"}, pred_score, 0);
        chk({tag, "_m_valid"},    m_valid,    0);
        chk({tag, "_m_data"},     m_data,     0);
        chk({tag, "_m_idx"},      m_idx,      0);
        chk({tag, "_m_last"},     m_last,     0);
        chk({tag, "_rd_data"},    rd_data,    0);
        chk({tag, "_rd_err"},     rd_err,     0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        capture = 1'b0;
        m_ready = 1'b0;
        rd_idx  = '0;
        scores  = '0;
        step();
        step();
        check_reset("reset");
        rst = 1'b0;
        step();

        // Ascending scores, m_ready held high.
        for (int i = 0; i < N; i++) vec[i] = score_t'(i * 100);
        m_ready = 1'b1;
        apply_capture();
        chk("t1_busy_at_T", busy, 1);
        chk("t1_m_valid_at_T", m_valid, 0);
        repeat (8) step();
        chk("t1_pred_valid_T8", pred_valid, 0);
        step();
        chk("t1_pred_valid_T9", pred_valid, 1);
        chk("t1_pred_idx", pred_idx, 9);
        chk("t1_pred_score", pred_score, 900);
        for (int k = 0; k < N; k++) begin
            chk("t1_m_valid", m_valid, 1);
            chk("t1_m_idx", m_idx, k);
            chk("t1_m_data", m_data, k * 100);
            chk("t1_m_last", m_last, (k == N - 1));
            step();
        end
        chk("t1_busy_T19", busy, 0);
        chk("t1_m_valid_T19", m_valid, 0);
        chk("t1_pred_hold", pred_valid, 1);

        // Random-access reads, including range boundaries.
        rd_idx = 4'd3;  step();
        chk("rd3_data", rd_data, 300);
        chk("rd3_err", rd_err, 0);
        rd_idx = 4'd9;  step();
        chk("rd9_data", rd_data, 900);
        chk("rd9_err", rd_err, 0);
        rd_idx = 4'd10; step();
        chk("rd10_data", rd_data, 0);
        chk("rd10_err", rd_err, 1);
        rd_idx = 4'd12; step();
        chk("rd12_data", rd_data, 0);
        chk("rd12_err", rd_err, 1);

        // Negative scores: signed compare.
        for (int i = 0; i < N; i++) vec[i] = -16'sd500;
        vec[4] = -16'sd3;
        apply_capture();
        repeat (9) step();
        chk("t2_pred_valid", pred_valid, 1);
        chk("t2_pred_idx", pred_idx, 4);
        chk("t2_pred_score", pred_score, -3);
        wait_idle(20);

        // Tie resolves to lower index; then a stalled stream with 1,0,0,1 ready.
        for (int i = 0; i < N; i++) vec[i] = '0;
        vec[2] = 16'sh7FFF;
        vec[7] = 16'sh7FFF;
        apply_capture();
        repeat (9) step();
        chk("t3_pred_idx", pred_idx, 2);
        chk("t3_pred_score", pred_score, 32767);
        beats = 0;
        for (int c = 0; c < 60 && busy; c++) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            chk("t4_m_valid", m_valid, 1);
            chk("t4_m_idx", m_idx, beats);
            chk("t4_m_data", m_data, (beats < N) ? vec[beats] : 0);
            chk("t4_m_last", m_last, (beats == N - 1));
            if (m_ready) beats++;
            step();
        end
        chk("t4_beat_count", beats, N);
        chk("t4_idle", busy, 0);
        m_ready = 1'b1;

        // Abort mid-scan with a new vector, then abort mid-stream.
        for (int i = 0; i < N; i++) vec[i] = score_t'(i * 100);
        apply_capture();
        repeat (4) step();
        for (int i = 0; i < N; i++) vec[i] = score_t'(i * 10);
        vec[5] = 16'sd5000;
        apply_capture();
        chk("t5_busy", busy, 1);
        chk("t5_pred_valid_clr", pred_valid, 0);
        repeat (8) step();
        chk("t5_pred_valid_early", pred_valid, 0);
        chk("t5_no_stale_beat", m_valid, 0);
        step();
        chk("t5_pred_valid", pred_valid, 1);
        chk("t5_pred_idx", pred_idx, 5);
        chk("t5_pred_score", pred_score, 5000);
        for (int k = 0; k < 3; k++) begin
            chk("t5_m_idx", m_idx, k);
            chk("t5_m_data", m_data, k * 10);
            step();
        end
        for (int i = 0; i < N; i++) vec[i] = score_t'(i * 100);
        apply_capture();
        chk("t5_abort_m_valid", m_valid, 0);
        chk("t5_abort_busy", busy, 1);
        chk("t5_abort_m_idx", m_idx, 0);
        repeat (9) step();
        chk("t5_restart_pred_idx", pred_idx, 9);
        chk("t5_restart_m_idx", m_idx, 0);
        wait_idle(30);

        // Read latency across a capture, then reset mid-scan.
        for (int i = 0; i < N; i++) vec[i] = score_t'(i * 100);
        vec[3] = 16'sd777;
        rd_idx = 4'd3;
        step();
        apply_capture();
        chk("t6_rd_old", rd_data, 300);
        step();
        chk("t6_rd_new", rd_data, 777);
        chk("t6_rd_err0", rd_err, 0);
        rd_idx = 4'd12;
        step();
        chk("t6_rd12_data", rd_data, 0);
        chk("t6_rd12_err", rd_err, 1);
        step();
        rst = 1'b1;
        #1;
        check_reset("midrst");
        step();
        rst = 1'b0;
        rd_idx = 4'd3;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t6_no_beat_after_rst", m_valid, 0);
        end
        chk("t6_snapshot_cleared", rd_data, 0);
        chk("t6_busy_after_rst", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
